dmem_sized_ctrl: RTL and testbench

Parametrised data-memory controller for the single-cycle/multicycle MIPS datapath. It handles MIPS byte, halfword and word loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw) over a word-organised array using byte lanes, with a request/ready handshake and a registered one-cycle read. It flags misaligned, out-of-range and illegal-opcode accesses. An optional post-reset sweep zero-fills the array. The block sits between the ALU address output and the write-back mux, and replaces the fixed 1024-word memory.

---
 rtl/dmem_sized_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dmem_sized_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sized_ctrl.sv
// Sized MIPS data-memory controller: byte/half/word loads and stores over a word array.
// Define DMEM_CLEAR_EN to zero-fill the array in an INIT sweep after reset.
module dmem_sized_ctrl #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpSb  = 6'b101000;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSw  = 6'b101011;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  typedef enum logic {StInit, StIdle} state_e;

  state_e r_state, w_state_next;

  logic [31:0]   r_mem [DEPTH];
  logic          r_done, r_err;
  logic [31:0]   r_rdata;

  logic          w_legal, w_store, w_sgn, w_oor, w_misal, w_err, w_accept, w_we;
  logic [1:0]    w_size, w_off;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wword, w_rword, w_ld;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign w_idx    = addr[AW+1:2];
  assign w_off    = addr[1:0];
  assign w_oor    = (addr >> (AW + 2)) != 32'd0;
  assign w_rword  = r_mem[w_idx];
  assign ready    = (r_state == StIdle) && !Reset;
  assign w_accept = req && ready;
  assign w_we     = w_accept && w_store && !w_err;

  always_comb begin
    w_legal = 1'b1;
    w_store = 1'b0;
    w_sgn   = 1'b0;
    w_size  = SzWord;
    case (op)
      OpLb:    begin w_size = SzByte; w_sgn = 1'b1; end
      OpLbu:   w_size = SzByte;
      OpLh:    begin w_size = SzHalf; w_sgn = 1'b1; end
      OpLhu:   w_size = SzHalf;
      OpLw:    w_size = SzWord;
      OpSb:    begin w_size = SzByte; w_store = 1'b1; end
      OpSh:    begin w_size = SzHalf; w_store = 1'b1; end
      OpSw:    w_store = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_misal = ((w_size == SzHalf) && addr[0]) || ((w_size == SzWord) && (w_off != 2'd0));
  assign w_err   = !w_legal || w_oor || w_misal;

  // Store data is replicated across lanes so the byte enables alone select the target.
  always_comb begin
    w_be    = 4'b1111;
    w_wword = wdata;
    case (w_size)
      SzByte: begin
        w_be    = 4'b0001 << w_off;
        w_wword = {4{wdata[7:0]}};
      end
      SzHalf: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wword = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = w_rword[7:0];
    case (w_off)
      2'd1:    w_byte = w_rword[15:8];
      2'd2:    w_byte = w_rword[23:16];
      2'd3:    w_byte = w_rword[31:24];
      default: ;
    endcase
    w_half = w_off[1] ? w_rword[31:16] : w_rword[15:0];
    w_ld   = w_rword;
    case (w_size)
      SzByte:  w_ld = w_sgn ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      SzHalf:  w_ld = w_sgn ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      default: ;
    endcase
  end

`ifdef DMEM_CLEAR_EN
  logic [AW-1:0] r_clr_ptr, w_clr_next;

  always_comb begin
    w_state_next = r_state;
    w_clr_next   = r_clr_ptr;
    case (r_state)
      StInit: begin
        w_clr_next = r_clr_ptr + 1'b1;
        if (r_clr_ptr == AW'(DEPTH - 1)) w_state_next = StIdle;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state   <= StInit;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_ptr <= w_clr_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (r_state == StInit) begin
      r_mem[r_clr_ptr] <= 32'h0;
    end else if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end
`else
  always_comb begin
    w_state_next = StIdle;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge CLK) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_done  <= w_accept;
      r_err   <= w_accept && w_err;
      r_rdata <= (w_accept && !w_err && !w_store) ? w_ld : 32'h0;
    end
  end

  assign done  = r_done;
  assign err   = r_err;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_dmem_sized_ctrl.sv
// Randomised self-checking bench for dmem_sized_ctrl against a byte-array reference model.
module tb_dmem_sized_ctrl;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NBYTES = DEPTH * 4;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  logic        CLK = 1'b0;
  logic        Reset, req;
  logic [5:0]  op;
  logic [31:0] addr, wdata;
  logic        ready, done, err;
  logic [31:0] rdata;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mdl [NBYTES];

  dmem_sized_ctrl #(.DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .req   (req),
    .op    (op),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .done  (done),
    .err   (err),
    .rdata (rdata)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat little-endian byte array.
  function automatic void model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd,
                                output logic e, output logic [31:0] rd);
    int n = 4;
    bit ld = 1'b0;
    bit sgn = 1'b0;
    bit legal = 1'b1;
    logic [31:0] v = 32'h0;
    case (o)
      LB:      begin n = 1; ld = 1'b1; sgn = 1'b1; end
      LBU:     begin n = 1; ld = 1'b1; end
      LH:      begin n = 2; ld = 1'b1; sgn = 1'b1; end
      LHU:     begin n = 2; ld = 1'b1; end
      LW:      begin n = 4; ld = 1'b1; end
      SB:      n = 1;
      SH:      n = 2;
      SW:      n = 4;
      default: legal = 1'b0;
    endcase
    e  = 1'b0;
    rd = 32'h0;
    if (!legal || a >= NBYTES || (a % n) != 0) begin
      e = 1'b1;
    end else if (ld) begin
      for (int i = 0; i < n; i++) v = v | (32'(mdl[int'(a) + i]) << (8 * i));
      if (sgn && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (sgn && n == 2) v = {{16{v[15]}}, v[15:0]};
      rd = v;
    end else begin
      for (int i = 0; i < n; i++) mdl[int'(a) + i] = wd[8*i +: 8];
    end
  endfunction

  // Called just after a rising edge; returns just after the edge that accepts the request.
  task automatic xfer(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd,
                      input string tag);
    logic        e;
    logic [31:0] r;
    check_eq({tag, ".ready"}, {31'h0, ready}, 32'h1);
    op = o; addr = a; wdata = wd; req = 1'b1;
    model(o, a, wd, e, r);
    @(posedge CLK); #1;
    check_eq({tag, ".done"}, {31'h0, done}, 32'h1);
    check_eq({tag, ".err"}, {31'h0, err}, {31'h0, e});
    check_eq({tag, ".rdata"}, rdata, r);
  endtask

  task automatic idle(input string tag);
    req = 1'b0;
    addr = $urandom; wdata = $urandom;
    @(posedge CLK); #1;
    check_eq({tag, ".idle_done"}, {31'h0, done}, 32'h0);
  endtask

  task automatic sweep_check(input string tag);
    for (int c = 0; c < int'(DEPTH); c++) begin
      check_eq({tag, ".ready_low"}, {31'h0, ready}, 32'h0);
      check_eq({tag, ".done_low"}, {31'h0, done}, 32'h0);
      @(posedge CLK); #1;
    end
    check_eq({tag, ".ready_rise"}, {31'h0, ready}, 32'h1);
    for (int i = 0; i < int'(NBYTES); i++) mdl[i] = 8'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops [8];
    logic [5:0] ro;
    logic [31:0] ra;
    ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW};
    Reset = 1'b1; req = 1'b0; op = 6'h0; addr = 32'h0; wdata = 32'h0;
    #1;
    check_eq("rst.ready", {31'h0, ready}, 32'h0);
    check_eq("rst.done", {31'h0, done}, 32'h0);
    check_eq("rst.err", {31'h0, err}, 32'h0);
    check_eq("rst.rdata", rdata, 32'h0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
`ifdef DMEM_CLEAR_EN
    req = 1'b1; op = LW; addr = 32'h0;
    sweep_check("init");
    xfer(LW, 32'h0, 32'h0, "lw0");
`else
    #1;
    check_eq("noclr.ready", {31'h0, ready}, 32'h1);
    @(posedge CLK); #1;
`endif
    for (int w = 0; w < int'(DEPTH); w++) xfer(SW, 32'(w * 4), $urandom, "fill");

    xfer(SW, 32'h04, 32'h11223344, "merge.sw");
    xfer(SB, 32'h06, 32'h55AACCAB, "merge.sb");
    xfer(LW, 32'h04, 32'h0, "merge.lw");
    check_eq("merge.const", rdata, 32'h11AB3344);
    xfer(LH, 32'h06, 32'h0, "merge.lh");
    xfer(LB, 32'h06, 32'h0, "merge.lb");
    xfer(LBU, 32'h06, 32'h0, "merge.lbu");
    xfer(LW, 32'h02, 32'h0, "err.lw_mis");
    xfer(SH, 32'h05, 32'hFFFF, "err.sh_mis");
    xfer(LW, 32'h04, 32'h0, "err.lw_after");
    xfer(SW, 32'h40, 32'h12345678, "err.sw_oor");
    xfer(LW, 32'h8000_0004, 32'h0, "err.lw_hi");
    xfer(6'h00, 32'h0, 32'h0, "err.op0");
    idle("gap");
    xfer(SW, 32'h08, 32'hDEADBEEF, "b2b.sw");
    xfer(LW, 32'h08, 32'h0, "b2b.lw");
    check_eq("b2b.const", rdata, 32'hDEADBEEF);
    idle("b2b");

    for (int k = 0; k < 300; k++) begin
      ro = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 6'($urandom);
      case ($urandom_range(0, 9))
        0:       ra = 32'($urandom_range(NBYTES, NBYTES + 15));
        1:       ra = $urandom | 32'h8000_0000;
        default: ra = 32'($urandom_range(0, NBYTES - 1));
      endcase
      xfer(ro, ra, $urandom, "rnd");
      if ($urandom_range(0, 5) == 0) idle("rnd");
    end

    // Reset during an outstanding response, then again part-way through the sweep.
    op = LW; addr = 32'h4; req = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b1; req = 1'b0;
    #1;
    check_eq("midrst.done", {31'h0, done}, 32'h0);
    check_eq("midrst.rdata", rdata, 32'h0);
    check_eq("midrst.ready", {31'h0, ready}, 32'h0);
    @(negedge CLK);
    Reset = 1'b0;
`ifdef DMEM_CLEAR_EN
    repeat (7) @(posedge CLK);
    #1;
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    sweep_check("resweep");
    xfer(LW, 32'h04, 32'h0, "resweep.lw4");
    xfer(LW, 32'(4 * $urandom_range(0, DEPTH - 1)), 32'h0, "resweep.lwr");
`else
    #1;
    check_eq("noclr.ready2", {31'h0, ready}, 32'h1);
    @(posedge CLK); #1;
    xfer(SW, 32'h0C, 32'hCAFEF00D, "post.sw");
    xfer(LHU, 32'h0E, 32'h0, "post.lhu");
`endif
    idle("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
